// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter that rasterises solid rectangle fills from several
// requesters onto the single pixel-write port of a 160x120 VGA adapter.
module vga_plot_arbiter #(
  parameter int NREQ  = 3,
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [8*NREQ-1:0]    rect_x,
  input  logic [7*NREQ-1:0]    rect_y,
  input  logic [8*NREQ-1:0]    rect_w,
  input  logic [7*NREQ-1:0]    rect_h,
  input  logic [9*NREQ-1:0]    rect_colour,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      done,
  output logic                 busy,
  output logic [7:0]           oX,
  output logic [6:0]           oY,
  output logic [8:0]           oColour,
  output logic                 oPlot
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;

  state_t state, state_nxt;

  logic [7:0] x_arr [NREQ];
  logic [6:0] y_arr [NREQ];
  logic [7:0] w_arr [NREQ];
  logic [6:0] h_arr [NREQ];
  logic [8:0] c_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign x_arr[i] = rect_x[8*i +: 8];
    assign y_arr[i] = rect_y[7*i +: 7];
    assign w_arr[i] = rect_w[8*i +: 8];
    assign h_arr[i] = rect_h[7*i +: 7];
    assign c_arr[i] = rect_colour[9*i +: 9];
  end

  logic [NREQ-1:0] req_q;
  logic [NREQ-1:0] eligible;
  logic [IW-1:0]   last;
  logic [IW-1:0]   win_q;
  logic [IW-1:0]   winner;
  logic [IW-1:0]   idx;
  logic            any_req;

  logic [7:0] x_q;
  logic [6:0] y_q;
  logic [7:0] w_q;
  logic [6:0] h_q;
  logic [8:0] c_q;
  logic [7:0] col;
  logic [6:0] row;

  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [8:0] base_c;
  logic [7:0] nxt_col;
  logic [6:0] nxt_row;
  logic [8:0] sum_x;
  logic [7:0] sum_y;
  logic       in_range;
  logic       last_px;
  logic       zero_area;

  // A request must be seen on two consecutive edges; this gives the one-cycle
  // sampling latency and lets a requester drop req in the IDLE cycle after done.
  always_comb begin
    eligible = req & req_q;
    winner   = last;
    any_req  = 1'b0;
    idx      = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = IW'((32'(last) + k) % NREQ);
      if (!any_req && eligible[idx]) begin
        any_req = 1'b1;
        winner  = idx;
      end
    end
  end

  // Pixel datapath looks one pixel ahead so oX/oY/oPlot can be registered.
  always_comb begin
    base_x  = x_q;
    base_y  = y_q;
    base_c  = c_q;
    nxt_col = '0;
    nxt_row = '0;
    if (state == LOAD) begin
      base_x = x_arr[win_q];
      base_y = y_arr[win_q];
      base_c = c_arr[win_q];
    end else if (col == w_q - 8'd1) begin
      nxt_col = '0;
      nxt_row = row + 7'd1;
    end else begin
      nxt_col = col + 8'd1;
      nxt_row = row;
    end
    sum_x     = {1'b0, base_x} + {1'b0, nxt_col};
    sum_y     = {1'b0, base_y} + {1'b0, nxt_row};
    in_range  = (sum_x <= 9'(X_MAX)) && (sum_y <= 8'(Y_MAX));
    last_px   = (col == w_q - 8'd1) && (row == h_q - 7'd1);
    zero_area = (w_arr[win_q] == '0) || (h_arr[win_q] == '0);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = LOAD;
      LOAD:    state_nxt = zero_area ? DONE : DRAW;
      DRAW:    if (last_px) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_q   <= '0;
      last    <= IW'(NREQ - 1);
      win_q   <= '0;
      grant   <= '0;
      done    <= '0;
      busy    <= 1'b0;
      oX      <= '0;
      oY      <= '0;
      oColour <= '0;
      oPlot   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      c_q     <= '0;
      col     <= '0;
      row     <= '0;
    end else begin
      req_q <= req;
      busy  <= (state_nxt != IDLE);
      done  <= '0;
      oPlot <= 1'b0;

      if (state == IDLE && any_req) begin
        win_q <= winner;
        grant <= NREQ'(1) << winner;
      end

      if (state == LOAD) begin
        x_q <= x_arr[win_q];
        y_q <= y_arr[win_q];
        w_q <= w_arr[win_q];
        h_q <= h_arr[win_q];
        c_q <= c_arr[win_q];
      end

      if (state_nxt == DRAW) begin
        col     <= nxt_col;
        row     <= nxt_row;
        oX      <= sum_x[7:0];
        oY      <= sum_y[6:0];
        oColour <= base_c;
        oPlot   <= in_range;
      end

      if (state_nxt == DONE) begin
        done  <= NREQ'(1) << win_q;
        grant <= '0;
        last  <= win_q;
      end
    end
  end

endmodule
